// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and types for the SPI transmit arbiter.
//   BYTE_W      : SPI byte width
//   DC_CMD/DATA : D/C select encoding
//   arb_state_e : arbiter FSM state encoding
//   max_u       : helper for sizing counters
package spi_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic DC_CMD  = 1'b0;
  localparam logic DC_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GAP   = 2'd3
  } arb_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/spi_tx_arbiter_if.sv
// spi_tx_arbiter_if: byte sources, SPI engine and status signals of the arbiter.
//   cmd_*  : command byte source (valid/data/ready)
//   dat_*  : data byte source (valid/data/last/ready)
//   spi_*  : start/data towards spi_master, done back from it
//   dc, busy, err, err_clr : D/C select, activity and sticky timeout status
// Modports: master = arbiter side, slave = surrounding environment.
interface spi_tx_arbiter_if;
  import spi_pkg::*;

  logic              cmd_valid;
  logic [BYTE_W-1:0] cmd_data;
  logic              cmd_ready;
  logic              dat_valid;
  logic [BYTE_W-1:0] dat_data;
  logic              dat_last;
  logic              dat_ready;
  logic              spi_start;
  logic [BYTE_W-1:0] spi_data;
  logic              spi_done;
  logic              dc;
  logic              busy;
  logic              err;
  logic              err_clr;

  modport master (
    input  cmd_valid, cmd_data, dat_valid, dat_data, dat_last, spi_done, err_clr,
    output cmd_ready, dat_ready, spi_start, spi_data, dc, busy, err
  );

  modport slave (
    output cmd_valid, cmd_data, dat_valid, dat_data, dat_last, spi_done, err_clr,
    input  cmd_ready, dat_ready, spi_start, spi_data, dc, busy, err
  );

endinterface

// File: rtl/spi_arb_gap_timer.sv
// spi_arb_gap_timer: loadable down-counter that saturates at zero.
//   clk, rst   : clock, synchronous active-high reset
//   i_load     : load i_load_val (has priority over i_dec)
//   i_load_val : value to load
//   i_dec      : decrement by one when non-zero
//   o_zero_c   : counter currently at zero (combinational)
module spi_arb_gap_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero_c
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero_c = (r_count == '0);

endmodule

// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: shares one SPI byte engine between a command and a data source.
//   clk, rst : clock, synchronous active-high reset
//   bus      : spi_tx_arbiter_if.master (sources, SPI engine, dc/busy/err)
// Commands have priority unless a data burst is in progress (lock); each byte
// is followed by GAP_CYCLES idle cycles after spi_done.
// Optional macro SPI_ARB_TIMEOUT_EN: abort WAIT after TIMEOUT_CYCLES, set sticky err.
module spi_tx_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic              clk,
  input logic              rst,
  spi_tx_arbiter_if.master bus
);

  localparam int unsigned CNT_MAX = max_u(GAP_CYCLES, TIMEOUT_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  arb_state_e        r_state;
  logic              r_lock;
  logic              r_spi_start;
  logic [BYTE_W-1:0] r_spi_data;
  logic              r_dc;
  logic              r_busy;
  logic              r_err;

  logic              w_cmd_acc;
  logic              w_dat_acc;
  logic              w_timeout;
  logic              w_wait_exit;
  logic              w_tmr_load;
  logic [CNT_W-1:0]  w_tmr_val;
  logic              w_tmr_dec;
  logic              w_tmr_zero;

  // Grant: only in IDLE; an open burst locks out commands.
  always_comb begin
    bus.cmd_ready = 1'b0;
    bus.dat_ready = 1'b0;
    if (r_state == ST_IDLE) begin
      if (r_lock) begin
        bus.dat_ready = bus.dat_valid;
      end else begin
        bus.cmd_ready = bus.cmd_valid;
        bus.dat_ready = bus.dat_valid & ~bus.cmd_valid;
      end
    end
  end

  assign w_cmd_acc = bus.cmd_valid & bus.cmd_ready;
  assign w_dat_acc = bus.dat_valid & bus.dat_ready;

`ifdef SPI_ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  // Timer loaded in ISSUE reaches zero on the last allowed WAIT cycle.
  assign w_timeout = (r_state == ST_WAIT) & ~bus.spi_done & w_tmr_zero;
`else
  assign w_timeout = 1'b0;
`endif

  assign w_wait_exit = (r_state == ST_WAIT) & (bus.spi_done | w_timeout);

  // Timer control: gap count after WAIT, optional timeout count during WAIT.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = GAP_LOAD;
    w_tmr_dec  = 1'b0;
    case (r_state)
`ifdef SPI_ARB_TIMEOUT_EN
      ST_ISSUE: begin
        w_tmr_load = 1'b1;
        w_tmr_val  = TMO_LOAD;
      end
      ST_WAIT: begin
        w_tmr_load = w_wait_exit;
        w_tmr_dec  = ~w_wait_exit;
      end
`else
      ST_WAIT:  w_tmr_load = w_wait_exit;
`endif
      ST_GAP:   w_tmr_dec  = 1'b1;
      default:  ;
    endcase
  end

  spi_arb_gap_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_zero_c   (w_tmr_zero)
  );

  // Sequencer: IDLE -> ISSUE -> WAIT -> (GAP) -> IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_lock      <= 1'b0;
      r_spi_start <= 1'b0;
      r_spi_data  <= '0;
      r_dc        <= DC_CMD;
      r_busy      <= 1'b0;
    end else begin
      r_spi_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cmd_acc) begin
            r_spi_data  <= bus.cmd_data;
            r_dc        <= DC_CMD;
            r_spi_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_ISSUE;
          end else if (w_dat_acc) begin
            r_spi_data  <= bus.dat_data;
            r_dc        <= DC_DATA;
            r_lock      <= ~bus.dat_last;
            r_spi_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (w_wait_exit) begin
            // An aborted byte ends the burst so commands are not starved.
            if (w_timeout) r_lock <= 1'b0;
            // Zero-gap builds have no GAP state to pass through.
            if (GAP_CYCLES > 0) begin
              r_state <= ST_GAP;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          if (w_tmr_zero) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // Sticky error; a timeout in the same cycle as err_clr keeps it set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_timeout) begin
      r_err <= 1'b1;
    end else if (bus.err_clr) begin
      r_err <= 1'b0;
    end
  end
`else
  logic w_unused_err_clr;
  assign w_unused_err_clr = bus.err_clr;
  assign r_err = 1'b0;
`endif

  assign bus.spi_start = r_spi_start;
  assign bus.spi_data  = r_spi_data;
  assign bus.dc        = r_dc;
  assign bus.busy      = r_busy;
  assign bus.err       = r_err;

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb_spi_tx_arbiter: directed self-checking bench for spi_tx_arbiter.
// u_dut uses GAP_CYCLES=2 with a 25-cycle spi_master model (done at T+26);
// u_dut0 uses GAP_CYCLES=0 with a 3-cycle model for back-to-back timing.
module tb_spi_tx_arbiter;
  import spi_pkg::*;

  localparam int LAT  = 25;
  localparam int LAT0 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_tx_arbiter_if bus_if ();
  spi_tx_arbiter_if bus0 ();

  spi_tx_arbiter #(
    .GAP_CYCLES     (2),
    .TIMEOUT_CYCLES (64)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  spi_tx_arbiter #(
    .GAP_CYCLES     (0),
    .TIMEOUT_CYCLES (64)
  ) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  bit         resp_en;
  logic [8:0] wire_q[$];
  logic [7:0] burst [3] = '{8'h01, 8'h02, 8'h03};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Call at a settled point; returns the cycle in which spi_done is high.
  task automatic wait_done(output int at);
    at = -1;
    for (int k = 0; k < 100; k++) begin
      if (bus_if.spi_done === 1'b1) begin
        at = cyc;
        break;
      end
      step();
      #1;
    end
    check_eq("wait_done_bound", 32'((at >= 0) ? 1 : 0), 32'd1);
  endtask

  task automatic wait_idle();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus_if.busy === 1'b0) begin
        seen = 1'b1;
        break;
      end
      step();
      #1;
    end
    check_eq("wait_idle_bound", 32'(seen), 32'd1);
  endtask

  // spi_master model for u_dut; also logs every byte put on the wire.
  initial begin : resp_main
    int cd;
    cd = -1;
    bus_if.spi_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus_if.spi_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus_if.spi_done = 1'b1;
          cd = -1;
        end
      end
      if (bus_if.spi_start === 1'b1) begin
        wire_q.push_back({bus_if.dc, bus_if.spi_data});
        if (resp_en) cd = LAT;
      end
    end
  end

  // spi_master model for u_dut0.
  initial begin : resp_zero
    int cd;
    cd = -1;
    bus0.spi_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus0.spi_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          bus0.spi_done = 1'b1;
          cd = -1;
        end
      end
      if (bus0.spi_start === 1'b1) cd = LAT0;
    end
  end

  initial begin : main
    int t0, d, e, acc2, dcy, idle_n, idx;
    bit cmd_raised, d_acc, c_acc, granted;

    rst     = 1'b1;
    resp_en = 1'b1;
    bus_if.cmd_valid = 1'b0; bus_if.cmd_data = 8'h00;
    bus_if.dat_valid = 1'b0; bus_if.dat_data = 8'h00; bus_if.dat_last = 1'b0;
    bus_if.err_clr   = 1'b0;
    bus0.cmd_valid   = 1'b0; bus0.cmd_data   = 8'h00;
    bus0.dat_valid   = 1'b0; bus0.dat_data   = 8'h00; bus0.dat_last = 1'b0;
    bus0.err_clr     = 1'b0;
    step();
    step();
    #1;

    // Reset values
    check_eq("rst_spi_start", 32'(bus_if.spi_start), 32'd0);
    check_eq("rst_spi_data",  32'(bus_if.spi_data),  32'h00);
    check_eq("rst_dc",        32'(bus_if.dc),        32'd0);
    check_eq("rst_busy",      32'(bus_if.busy),      32'd0);
    check_eq("rst_err",       32'(bus_if.err),       32'd0);
    bus_if.cmd_valid = 1'b1;
    #1;
    check_eq("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    bus_if.cmd_valid = 1'b0;
    rst = 1'b0;
    step();

    // Command byte 0x2A, then next grant no earlier than D+3
    bus_if.cmd_valid = 1'b1; bus_if.cmd_data = 8'h2A;
    #1;
    check_eq("t1_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    check_eq("t1_dat_ready", 32'(bus_if.dat_ready), 32'd0);
    t0 = cyc;
    step();
    bus_if.cmd_valid = 1'b0;
    #1;
    check_eq("t1_start",    32'(bus_if.spi_start), 32'd1);
    check_eq("t1_spi_data", 32'(bus_if.spi_data),  32'h2A);
    check_eq("t1_dc",       32'(bus_if.dc),        32'd0);
    check_eq("t1_busy",     32'(bus_if.busy),      32'd1);
    step();
    #1;
    check_eq("t1_start_one", 32'(bus_if.spi_start), 32'd0);
    wait_done(d);
    check_eq("t1_done_lat", 32'(d - t0), 32'd26);
    bus_if.cmd_valid = 1'b1; bus_if.cmd_data = 8'h33;
    #1;
    check_eq("t1_rdy_D",   32'(bus_if.cmd_ready), 32'd0);
    step(); #1;
    check_eq("t1_rdy_D1",  32'(bus_if.cmd_ready), 32'd0);
    check_eq("t1_busy_D1", 32'(bus_if.busy),      32'd1);
    step(); #1;
    check_eq("t1_rdy_D2",  32'(bus_if.cmd_ready), 32'd0);
    step(); #1;
    check_eq("t1_rdy_D3",  32'(bus_if.cmd_ready), 32'd1);
    check_eq("t1_busy_D3", 32'(bus_if.busy),      32'd0);
    step();
    bus_if.cmd_valid = 1'b0;
    #1;
    wait_done(d);
    wait_idle();

    // Priority: command beats data when unlocked
    wire_q.delete();
    bus_if.cmd_valid = 1'b1; bus_if.cmd_data = 8'h11;
    bus_if.dat_valid = 1'b1; bus_if.dat_data = 8'hA5; bus_if.dat_last = 1'b1;
    #1;
    check_eq("t2_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    check_eq("t2_dat_held",  32'(bus_if.dat_ready), 32'd0);
    step();
    bus_if.cmd_valid = 1'b0;
    #1;
    granted = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (bus_if.dat_ready === 1'b1) begin
        granted = 1'b1;
        break;
      end
      step();
      #1;
    end
    check_eq("t2_dat_granted", 32'(granted), 32'd1);
    step();
    bus_if.dat_valid = 1'b0;
    #1;
    wait_done(d);
    wait_idle();
    check_eq("t2_n_bytes", 32'(wire_q.size()), 32'd2);
    check_eq("t2_byte0",   32'(wire_q[0]),     32'h011);
    check_eq("t2_byte1",   32'(wire_q[1]),     32'h1A5);

    // Burst lock: command raised after first burst byte waits for the end
    wire_q.delete();
    idx = 0;
    cmd_raised = 1'b0;
    bus_if.dat_valid = 1'b1; bus_if.dat_data = burst[0]; bus_if.dat_last = 1'b0;
    for (int k = 0; k < 400; k++) begin
      #1;
      d_acc = bus_if.dat_valid & bus_if.dat_ready;
      c_acc = bus_if.cmd_valid & bus_if.cmd_ready;
      step();
      if (c_acc) bus_if.cmd_valid = 1'b0;
      if (d_acc) begin
        if (!cmd_raised) begin
          bus_if.cmd_valid = 1'b1;
          bus_if.cmd_data  = 8'h55;
          cmd_raised = 1'b1;
        end
        idx++;
        if (idx < 3) begin
          bus_if.dat_data = burst[idx];
          bus_if.dat_last = (idx == 2);
        end else begin
          bus_if.dat_valid = 1'b0;
        end
      end
      if (idx == 3 && cmd_raised && !bus_if.cmd_valid) break;
    end
    check_eq("t3_all_accepted", 32'((idx == 3 && !bus_if.cmd_valid) ? 1 : 0), 32'd1);
    #1;
    wait_done(d);
    wait_idle();
    check_eq("t3_n_bytes", 32'(wire_q.size()), 32'd4);
    check_eq("t3_byte0",   32'(wire_q[0]),     32'h101);
    check_eq("t3_byte1",   32'(wire_q[1]),     32'h102);
    check_eq("t3_byte2",   32'(wire_q[2]),     32'h103);
    check_eq("t3_byte3",   32'(wire_q[3]),     32'h055);

    // GAP_CYCLES=0: second accept in D+1, busy low for exactly that cycle
    bus0.dat_valid = 1'b1; bus0.dat_data = 8'hC1; bus0.dat_last = 1'b0;
    #1;
    check_eq("g0_rdy_first", 32'(bus0.dat_ready), 32'd1);
    t0 = cyc;
    step();
    bus0.dat_data = 8'hC2; bus0.dat_last = 1'b1;
    acc2 = -1; dcy = -1; idle_n = 0;
    for (int k = 0; k < 30; k++) begin
      #1;
      if (bus0.spi_done === 1'b1) dcy = cyc;
      if (bus0.busy === 1'b0) idle_n++;
      if (bus0.dat_ready === 1'b1) begin
        acc2 = cyc;
        break;
      end
      step();
    end
    check_eq("g0_done_at",   32'(dcy - t0),    32'd4);
    check_eq("g0_acc2_at",   32'(acc2 - dcy),  32'd1);
    check_eq("g0_idle_cyc",  32'(idle_n),      32'd1);
    step();
    bus0.dat_valid = 1'b0;
    #1;
    check_eq("g0_busy_back", 32'(bus0.busy),      32'd1);
    check_eq("g0_start2",    32'(bus0.spi_start), 32'd1);
    check_eq("g0_data2",     32'(bus0.spi_data),  32'hC2);
    check_eq("g0_dc2",       32'(bus0.dc),        32'd1);

    // Timeout behaviour with spi_done held low
    resp_en = 1'b0;
    bus_if.dat_valid = 1'b1; bus_if.dat_data = 8'h9C; bus_if.dat_last = 1'b0;
    #1;
    check_eq("to_dat_ready", 32'(bus_if.dat_ready), 32'd1);
    t0 = cyc;
    step();
    bus_if.dat_valid = 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
    #1;
    e = -1;
    for (int k = 0; k < 200; k++) begin
      if (bus_if.err === 1'b1) begin
        e = cyc;
        break;
      end
      step();
      #1;
    end
    check_eq("to_err_at",   32'(e - t0),       32'd66);
    check_eq("to_busy_g0",  32'(bus_if.busy),  32'd1);
    step(); #1;
    check_eq("to_busy_g1",  32'(bus_if.busy),  32'd1);
    step(); #1;
    check_eq("to_idle",     32'(bus_if.busy),  32'd0);
    check_eq("to_err_held", 32'(bus_if.err),   32'd1);
    bus_if.cmd_valid = 1'b1; bus_if.dat_valid = 1'b1; bus_if.dat_last = 1'b1;
    #1;
    check_eq("to_unlock_cmd", 32'(bus_if.cmd_ready), 32'd1);
    check_eq("to_unlock_dat", 32'(bus_if.dat_ready), 32'd0);
    bus_if.cmd_valid = 1'b0; bus_if.dat_valid = 1'b0;
    bus_if.err_clr = 1'b1;
    step();
    bus_if.err_clr = 1'b0;
    #1;
    check_eq("to_err_clr", 32'(bus_if.err), 32'd0);
    // Leave a locked burst byte stuck in WAIT for the reset check
    bus_if.dat_valid = 1'b1; bus_if.dat_data = 8'h9D; bus_if.dat_last = 1'b0;
    step();
    bus_if.dat_valid = 1'b0;
    step(); step(); step();
    #1;
    check_eq("rw_busy_pre", 32'(bus_if.busy), 32'd1);
`else
    bus_if.err_clr = 1'b1;
    repeat (100) step();
    bus_if.err_clr = 1'b0;
    #1;
    check_eq("to_busy_stuck", 32'(bus_if.busy), 32'd1);
    check_eq("to_err_zero",   32'(bus_if.err),  32'd0);
`endif

    // Reset mid-WAIT: outputs back to reset values, lock gone, command accepted
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus_if.cmd_valid = 1'b1; bus_if.cmd_data = 8'h5A;
    bus_if.dat_valid = 1'b1; bus_if.dat_data = 8'h66; bus_if.dat_last = 1'b1;
    #1;
    check_eq("rw_spi_start", 32'(bus_if.spi_start), 32'd0);
    check_eq("rw_spi_data",  32'(bus_if.spi_data),  32'h00);
    check_eq("rw_dc",        32'(bus_if.dc),        32'd0);
    check_eq("rw_busy",      32'(bus_if.busy),      32'd0);
    check_eq("rw_err",       32'(bus_if.err),       32'd0);
    check_eq("rw_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    check_eq("rw_dat_ready", 32'(bus_if.dat_ready), 32'd0);
    step();
    bus_if.cmd_valid = 1'b0; bus_if.dat_valid = 1'b0;
    #1;
    check_eq("rw_start",     32'(bus_if.spi_start), 32'd1);
    check_eq("rw_data",      32'(bus_if.spi_data),  32'h5A);
    check_eq("rw_dc_cmd",    32'(bus_if.dc),        32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_tx_arbiter.md
# spi_tx_arbiter

Sequencer and arbiter in front of `spi_master`. It shares the single SPI byte engine between two byte sources:
- a command requester, which carries controller init and configuration bytes;
- a data requester, which carries sample and pixel bursts.

The block drives the D/C select line, enforces an inter-byte gap, and keeps data bursts atomic. It sits between the display/capture front end and the SPI master.

## Interface
Parameters:
- `GAP_CYCLES`, default 2: idle cycles inserted after each `spi_done` before the next grant (0 allowed).
- `TIMEOUT_CYCLES`, default 64: maximum WAIT cycles before abort. Used only with `SPI_ARB_TIMEOUT_EN`. Must be ≥ 32.

Ports (reset is synchronous and active-high; one clock):
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command byte offered.
- `cmd_data` in 8: command byte.
- `cmd_ready` out 1: command byte accepted this cycle when `cmd_valid` is also high.
- `dat_valid` in 1: data byte offered.
- `dat_data` in 8: data byte.
- `dat_last` in 1: final byte of the current data burst.
- `dat_ready` out 1: data byte accepted this cycle when `dat_valid` is also high.
- `spi_start` out 1: one-cycle start pulse to `spi_master`.
- `spi_data` out 8: byte to `spi_master`, stable from ISSUE until the next accept.
- `spi_done` in 1: byte-complete pulse from `spi_master`.
- `dc` out 1: 0 = command, 1 = data. Held from accept until the next accept.
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: sticky timeout flag.
- `err_clr` in 1: clears `err`.

## Operation
States and transitions:
- **IDLE**
  - With `lock`=0, priority goes to the command source: `cmd_ready` = `cmd_valid`, and `dat_ready` = `dat_valid & ~cmd_valid`.
  - With `lock`=1, `cmd_ready`=0 and `dat_ready`=`dat_valid`.
  - Ready signals are combinational from state, `lock` and the valid inputs; both are 0 outside IDLE.
  - On accept (valid & ready), latch the byte into `spi_data`, set `dc` (0 for cmd, 1 for data), and go to ISSUE.
- **ISSUE**: `spi_start`=1 for exactly one cycle, then go to WAIT.
- **WAIT**: hold until `spi_done`=1, then go to GAP (GAP_CYCLES > 0) or IDLE (GAP_CYCLES = 0).
- **GAP**: the counter runs 0 to GAP_CYCLES-1, then the block goes to IDLE.

Burst lock:
- Accepting a data byte with `dat_last`=0 sets `lock`.
- Accepting a data byte with `dat_last`=1 clears `lock`.
- A pending command therefore waits until the burst ends.

Boundary behaviour:
- A single-byte burst (`dat_last`=1 on the first byte) never sets `lock`.
- Simultaneous `cmd_valid` and `dat_valid` with `lock`=0: the command wins; the data source holds its byte.
- Simultaneous `cmd_valid` and `dat_valid` with `lock`=1: the data byte wins.
- `spi_done` outside WAIT is ignored.
- `rst` mid-transfer puts the block in IDLE and clears `lock`. `spi_master` shares `rst`, so no byte is left half-sent.

Reset values: state=IDLE, `lock`=0, `spi_start`=0, `spi_data`=0x00, `dc`=0, `busy`=0, `err`=0. `cmd_ready`/`dat_ready` follow the combinational rule with the IDLE state.

## Timing
- Accept in cycle T.
- `spi_start`=1 and `spi_data`/`dc` valid in T+1.
- WAIT begins in T+2.
- `spi_done` arrives in cycle D (for the current `spi_master`, D = T+26).
- The next accept is possible in cycle D+1+GAP_CYCLES.
- Throughput: one byte per (D−T)+1+GAP_CYCLES cycles.
- `busy` rises in T+1 and falls when the block re-enters IDLE.

## Configuration
Macro: `SPI_ARB_TIMEOUT_EN`.

Defined:
- A WAIT-cycle counter runs in WAIT.
- When the counter reaches TIMEOUT_CYCLES without `spi_done`, the block sets `err`, clears `lock`, and goes to GAP.
- `err` stays set until `err_clr`=1, which clears it the next cycle. `err_clr` and a new timeout in the same cycle: set wins.

Not defined:
- No counter; WAIT holds indefinitely.
- `err` is tied to 0 and `err_clr` is ignored.

## Structure
Shared package `spi_pkg` holds:
- the state encoding localparams (IDLE, ISSUE, WAIT, GAP);
- `DC_CMD`=0 and `DC_DATA`=1;
- the byte width constant 8.

One sub-module, `spi_arb_gap_timer`, serves as a loadable down-counter. It is shared by GAP timing and, when enabled, the timeout. The rest is the FSM and grant logic in `spi_tx_arbiter`.

## Test plan
- **Command byte**: `cmd_valid`=1 with 0x2A → `cmd_ready` in T; `spi_start` in T+1 with `spi_data`=0x2A and `dc`=0; the next grant is not earlier than `spi_done`+1+2.
- **Priority**: `cmd`=0x11 and `dat`=0xA5 (`dat_last`=1) offered together → 0x11 (dc=0) is sent first, then 0xA5 (dc=1).
- **Burst lock**: data 0x01, 0x02, 0x03 (`last` on 0x03), with `cmd`=0x55 raised after 0x01 is accepted → order on the wire is 0x01, 0x02, 0x03, 0x55.
- **GAP_CYCLES=0 back-to-back**: two data bytes → second accept in D+1; `busy` low for exactly that one cycle.
- **Timeout** (macro on, `spi_done` held 0): `err`=1 at WAIT cycle 64, the block returns to IDLE after the gap, and `err_clr` clears `err`. With the macro off, `busy` stays 1.
- **Reset mid-WAIT**: `rst` pulsed 1 cycle → next cycle all outputs at their reset values, `lock`=0, and a new command is accepted immediately.
